dac_mode_fsm: RTL and testbench

Mode controller for the digital alarm clock. It turns four debounced push-button levels and the 1 Hz tick into the control strobes for the time/alarm set register and the clock/alarm storage. Those strobes are `show_time`, `show_alarm`, `inc_min`, `inc_hr`, `load_new_time` and `load_new_alarm`. The block sits between the key debouncer and the set-counter / alarm-register datapath, and owns all display-mode sequencing and edit timeout.

---
 rtl/dac_mode_fsm_if.sv | 33 +++
 rtl/dac_mode_fsm.sv | 152 +++++++++++++++
 tb/tb_dac_mode_fsm.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_mode_fsm_if.sv
// rtl/dac_mode_fsm_if.sv - key/tick inputs and control strobes of the alarm-clock mode controller
//
// Purpose: groups the debounced keys, the 1 Hz tick and the mode/strobe outputs.
// Ports (slave = controller side):
//   one_second, time_btn, alarm_btn, min_btn, hr_btn   : into the controller
//   show_time, show_alarm, editing                     : level outputs
//   inc_min, inc_hr, load_new_time, load_new_alarm     : one-cycle pulse outputs
interface dac_mode_fsm_if;
    logic one_second;
    logic time_btn;
    logic alarm_btn;
    logic min_btn;
    logic hr_btn;
    logic show_time;
    logic show_alarm;
    logic editing;
    logic inc_min;
    logic inc_hr;
    logic load_new_time;
    logic load_new_alarm;

    modport master (
        output one_second, time_btn, alarm_btn, min_btn, hr_btn,
        input  show_time, show_alarm, editing,
        input  inc_min, inc_hr, load_new_time, load_new_alarm
    );

    modport slave (
        input  one_second, time_btn, alarm_btn, min_btn, hr_btn,
        output show_time, show_alarm, editing,
        output inc_min, inc_hr, load_new_time, load_new_alarm
    );
endinterface

// File: rtl/dac_mode_fsm.sv
// rtl/dac_mode_fsm.sv - display-mode sequencing, edit strobes and edit timeout for the alarm clock
//
// Purpose: turns key edges and the 1 Hz tick into show/edit levels and
// increment/commit pulses, abandoning an alarm view or edit after TIMEOUT_S
// idle seconds.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : dac_mode_fsm_if.slave (keys, tick, levels, pulses)
module dac_mode_fsm #(
    parameter int TIMEOUT_S = 10
) (
    input  logic             clk,
    input  logic             reset,
    dac_mode_fsm_if.slave    bus
);

    localparam int CW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        SHOW_ALARM = 2'd1,
        SET_TIME   = 2'd2,
        SET_ALARM  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        time_q;
    logic        alarm_q;
    logic        min_q;
    logic        hr_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    logic inc_min_r, inc_min_d;
    logic inc_hr_r, inc_hr_d;
    logic load_time_r, load_time_d;
    logic load_alarm_r, load_alarm_d;
    logic accepted;

    logic time_e;
    logic alarm_e;
    logic min_e;
    logic hr_e;
    logic timeout_tick;

    assign time_e  = bus.time_btn  & ~time_q;
    assign alarm_e = bus.alarm_btn & ~alarm_q;
    assign min_e   = bus.min_btn   & ~min_q;
    assign hr_e    = bus.hr_btn    & ~hr_q;

    // Last idle second: the tick that would bring the count to TIMEOUT_S.
    assign timeout_tick = bus.one_second && (cnt == CW'(TIMEOUT_S - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SHOW_TIME;
            time_q       <= 1'b0;
            alarm_q      <= 1'b0;
            min_q        <= 1'b0;
            hr_q         <= 1'b0;
            cnt          <= '0;
            inc_min_r    <= 1'b0;
            inc_hr_r     <= 1'b0;
            load_time_r  <= 1'b0;
            load_alarm_r <= 1'b0;
        end else begin
            state        <= state_d;
            time_q       <= bus.time_btn;
            alarm_q      <= bus.alarm_btn;
            min_q        <= bus.min_btn;
            hr_q         <= bus.hr_btn;
            cnt          <= cnt_d;
            inc_min_r    <= inc_min_d;
            inc_hr_r     <= inc_hr_d;
            load_time_r  <= load_time_d;
            load_alarm_r <= load_alarm_d;
        end
    end

    always_comb begin
        state_d      = state;
        inc_min_d    = 1'b0;
        inc_hr_d     = 1'b0;
        load_time_d  = 1'b0;
        load_alarm_d = 1'b0;
        accepted     = 1'b0;
        cnt_d        = cnt;

        // Each branch is an if/else chain so only the highest-priority edge acts.
        case (state)
            SHOW_TIME: begin
                // The time key has no meaning here, so it does not block others.
                if (alarm_e) begin
                    state_d  = SHOW_ALARM;
                    accepted = 1'b1;
                end else if (min_e || hr_e) begin
                    state_d  = SET_TIME;
                    accepted = 1'b1;
                end
            end
            SHOW_ALARM: begin
                if (time_e || alarm_e) begin
                    state_d  = SHOW_TIME;
                    accepted = 1'b1;
                end else if (min_e || hr_e) begin
                    state_d  = SET_ALARM;
                    accepted = 1'b1;
                end else if (timeout_tick) begin
                    state_d  = SHOW_TIME;
                end
            end
            default: begin
                // SET_TIME and SET_ALARM behave identically; the commit key
                // alone selects the load target.
                if (time_e) begin
                    load_time_d = 1'b1;
                    state_d     = SHOW_TIME;
                    accepted    = 1'b1;
                end else if (alarm_e) begin
                    load_alarm_d = 1'b1;
                    state_d      = SHOW_TIME;
                    accepted     = 1'b1;
                end else if (min_e) begin
                    inc_min_d = 1'b1;
                    accepted  = 1'b1;
                end else if (hr_e) begin
                    inc_hr_d = 1'b1;
                    accepted = 1'b1;
                end else if (timeout_tick) begin
                    state_d = SHOW_TIME;
                end
            end
        endcase

        if ((state_d != state) || accepted) begin
            cnt_d = '0;
        end else if (bus.one_second && (state != SHOW_TIME)) begin
            cnt_d = cnt + CW'(1);
        end
    end

    assign bus.show_time      = (state == SHOW_TIME);
    assign bus.show_alarm     = (state == SHOW_ALARM);
    assign bus.editing        = (state == SET_TIME) || (state == SET_ALARM);
    assign bus.inc_min        = inc_min_r;
    assign bus.inc_hr         = inc_hr_r;
    assign bus.load_new_time  = load_time_r;
    assign bus.load_new_alarm = load_alarm_r;

endmodule

// File: tb/tb_dac_mode_fsm.sv
// tb/tb_dac_mode_fsm.sv - scoreboard bench for dac_mode_fsm
module tb_dac_mode_fsm;

    localparam int TO = 10;

    // Reference model modes and key identities.
    localparam int M_SHOWT = 0;
    localparam int M_SHOWA = 1;
    localparam int M_EDITT = 2;
    localparam int M_EDITA = 3;
    localparam int K_NONE  = 0;
    localparam int K_TIME  = 1;
    localparam int K_ALARM = 2;
    localparam int K_MIN   = 3;
    localparam int K_HR    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dac_mode_fsm_if bus ();

    dac_mode_fsm #(.TIMEOUT_S(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Expected {show_time, show_alarm, editing, inc_min, inc_hr, load_new_time, load_new_alarm}
    logic [6:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cycle_no = 0;

    int m_mode  = M_SHOWT;
    int m_timer = 0;
    bit p_t, p_a, p_m, p_h;

    task automatic model_step(input bit r, input bit t, input bit a, input bit m,
                              input bit h, input bit tk, output logic [6:0] e);
        int key;
        bit et, ea, em, eh;
        bit im, ih, lt, la;
        im = 0; ih = 0; lt = 0; la = 0;
        if (r) begin
            m_mode = M_SHOWT; m_timer = 0;
            p_t = 0; p_a = 0; p_m = 0; p_h = 0;
        end else begin
            et = t && !p_t; ea = a && !p_a; em = m && !p_m; eh = h && !p_h;
            key = K_NONE;
            if (m_mode == M_SHOWT) begin
                if (ea) key = K_ALARM;
                else if (em) key = K_MIN;
                else if (eh) key = K_HR;
            end else begin
                if (et) key = K_TIME;
                else if (ea) key = K_ALARM;
                else if (em) key = K_MIN;
                else if (eh) key = K_HR;
            end
            if (key != K_NONE) begin
                m_timer = 0;
                if (m_mode == M_SHOWT) begin
                    m_mode = (key == K_ALARM) ? M_SHOWA : M_EDITT;
                end else if (m_mode == M_SHOWA) begin
                    m_mode = (key == K_TIME || key == K_ALARM) ? M_SHOWT : M_EDITA;
                end else begin
                    case (key)
                        K_TIME:  begin lt = 1; m_mode = M_SHOWT; end
                        K_ALARM: begin la = 1; m_mode = M_SHOWT; end
                        K_MIN:   im = 1;
                        default: ih = 1;
                    endcase
                end
            end else if (tk && m_mode != M_SHOWT) begin
                m_timer++;
                if (m_timer == TO) begin
                    m_mode = M_SHOWT;
                    m_timer = 0;
                end
            end
            p_t = t; p_a = a; p_m = m; p_h = h;
        end
        e = {m_mode == M_SHOWT, m_mode == M_SHOWA,
             m_mode == M_EDITT || m_mode == M_EDITA, im, ih, lt, la};
    endtask

    // Driver: one cycle of stimulus, applied on the falling edge.
    task automatic cyc(input bit r, input bit t, input bit a, input bit m,
                       input bit h, input bit tk);
        logic [6:0] e;
        @(negedge clk);
        reset          = r;
        bus.time_btn   = t;
        bus.alarm_btn  = a;
        bus.min_btn    = m;
        bus.hr_btn     = h;
        bus.one_second = tk;
        model_step(r, t, a, m, h, tk, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit tk);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, tk);
    endtask

    // key: 1=time 2=alarm 3=min 4=hr; press one cycle then release one cycle
    task automatic press(input int key);
        cyc(0, key == 1, key == 2, key == 3, key == 4, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: compares every registered output set against the scoreboard.
    always @(posedge clk) begin
        #1;
        cycle_no++;
        if (exp_q.size() > 0) begin
            logic [6:0] got, want;
            want = exp_q.pop_front();
            got = {bus.show_time, bus.show_alarm, bus.editing, bus.inc_min,
                   bus.inc_hr, bus.load_new_time, bus.load_new_alarm};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cycle %0d: got st/sa/ed/im/ih/lt/la=%b required %b",
                         cycle_no, got, want);
            end
        end
    end

    initial begin
        bit rt, ra, rm, rh;
        reset = 1'b1;
        bus.time_btn = 0; bus.alarm_btn = 0; bus.min_btn = 0; bus.hr_btn = 0;
        bus.one_second = 0;

        // Reset and idle
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, (i % 3) == 0);

        // Time edit
        press(3);
        for (int i = 0; i < 3; i++) press(3);
        for (int i = 0; i < 2; i++) press(4);
        press(1);
        idle(2, 0);

        // Alarm edit
        press(2); press(4); press(3); press(2);
        idle(2, 0);

        // Timeout: 10 ticks in SET_TIME
        press(3); ticks(10); idle(2, 0);
        // 9 ticks, min edge, 9 ticks: still editing
        press(4); ticks(9); press(3); ticks(9); idle(2, 0);
        press(1);
        // Alarm view timeout
        press(2); ticks(TO); idle(2, 0);

        // Simultaneous edges
        press(3);
        cyc(0, 1, 0, 1, 1, 0); cyc(0, 0, 0, 0, 0, 0);
        press(3);
        cyc(0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 0, 0, 0);
        // Edge coinciding with the final timeout tick
        ticks(TO - 1);
        cyc(0, 0, 0, 1, 0, 1); cyc(0, 0, 0, 0, 0, 0);
        ticks(TO - 1);
        press(1);

        // Held button then reset mid-edit
        press(4);
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        idle(3, 0);

        // Randomised traffic
        rt = 0; ra = 0; rm = 0; rh = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) rt = !rt;
            if ($urandom_range(0, 15) == 0) ra = !ra;
            if ($urandom_range(0, 11) == 0) rm = !rm;
            if ($urandom_range(0, 11) == 0) rh = !rh;
            if ($urandom_range(0, 7) == 0) begin
                rt = $urandom_range(0, 1); ra = $urandom_range(0, 1);
                rm = $urandom_range(0, 1); rh = $urandom_range(0, 1);
            end
            cyc($urandom_range(0, 599) == 0, rt, ra, rm, rh, $urandom_range(0, 2) == 0);
        end
        idle(2, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
